// File: rtl/mem_write_tracer.sv
// Store trace FIFO (FWFT, count/rd_valid 1 cycle after push, pop holds head until rd_ready) plus sticky self-test checker.
// Optional capture timestamps with MEM_TRACE_TIMESTAMP_EN; without it rd_time is tied to 0.
module mem_write_tracer #(
  parameter int          DEPTH      = 16,
  parameter logic [31:0] CHECK_ADDR = 32'd100,
  parameter logic [31:0] CHECK_DATA = 32'd25,
  parameter int          TS_WIDTH   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    trace_en,
  input  logic                    clear,
  input  logic                    mem_write,
  input  logic [31:0]             mem_addr,
  input  logic [31:0]             mem_wdata,
  input  logic                    rd_ready,
  output logic                    rd_valid,
  output logic [31:0]             rd_addr,
  output logic [31:0]             rd_data,
  output logic [TS_WIDTH-1:0]     rd_time,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    success,
  output logic                    fail
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [31:0]   addr_mem [DEPTH];
  logic [31:0]   data_mem [DEPTH];

  logic push_req;
  logic full;
  logic do_push;
  logic do_pop;
  logic flush;

  assign flush    = reset | clear;
  assign push_req = trace_en & mem_write;
  assign full     = (count == FULL_CNT);
  assign rd_valid = (count != '0);
  assign do_pop   = rd_valid & rd_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept
  assign do_push  = push_req & (~full | do_pop);

  assign rd_addr = rd_valid ? addr_mem[rd_ptr] : '0;
  assign rd_data = rd_valid ? data_mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      addr_mem[wr_ptr] <= mem_addr;
      data_mem[wr_ptr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      success  <= 1'b0;
      fail     <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req && full && !do_pop) overflow <= 1'b1;
      // Checker watches the raw store port regardless of trace_en
      if (mem_write && (mem_addr == CHECK_ADDR)) begin
        if (mem_wdata == CHECK_DATA) success <= 1'b1;
        else                         fail    <= 1'b1;
      end
    end
  end

`ifdef MEM_TRACE_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_cnt;
  logic [TS_WIDTH-1:0] ts_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (flush) ts_cnt <= '0;
    else       ts_cnt <= ts_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) ts_mem[wr_ptr] <= ts_cnt;
  end

  assign rd_time = rd_valid ? ts_mem[rd_ptr] : '0;
`else
  assign rd_time = '0;
`endif

endmodule

// File: tb/tb_mem_write_tracer.sv
// Bench for mem_write_tracer: reset, vector table, directed full/clear/timestamp sequences, randomized run vs queue model.
module tb_mem_write_tracer;
  localparam int DEPTH = 16;
  localparam int TSW   = 4;

  logic            clk = 0;
  logic            reset, trace_en, clear, mem_write, rd_ready;
  logic [31:0]     mem_addr, mem_wdata;
  logic            rd_valid, overflow, success, fail;
  logic [31:0]     rd_addr, rd_data;
  logic [TSW-1:0]  rd_time;
  logic [4:0]      count;

  mem_write_tracer #(.DEPTH(DEPTH), .CHECK_ADDR(32'd100), .CHECK_DATA(32'd25), .TS_WIDTH(TSW)) dut (
    .clk(clk), .reset(reset), .trace_en(trace_en), .clear(clear), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .rd_ready(rd_ready), .rd_valid(rd_valid),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_time(rd_time), .count(count),
    .overflow(overflow), .success(success), .fail(fail));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference model: queue of stores plus flags, stepped once per clock edge
  typedef struct { logic [31:0] a; logic [31:0] d; int ts; } ent_t;
  ent_t q[$];
  logic m_ovf, m_suc, m_fail;
  int   m_ts;

  task automatic model_step(input logic r, c, te, mw, input logic [31:0] a, d, input logic rr);
    bit pop;
    ent_t e;
    if (r || c) begin
      q.delete(); m_ovf = 0; m_suc = 0; m_fail = 0; m_ts = 0;
    end else begin
      pop = (q.size() > 0) && rr;
      if (te && mw && q.size() == DEPTH && !pop) m_ovf = 1;
      if (pop) void'(q.pop_front());
      if (te && mw && q.size() < DEPTH) begin
        e.a = a; e.d = d; e.ts = m_ts; q.push_back(e);
      end
      if (mw && a == 32'd100) begin
        if (d == 32'd25) m_suc = 1; else m_fail = 1;
      end
      m_ts = (m_ts + 1) % (1 << TSW);
    end
  endtask

  task automatic model_check();
    chk("count", 32'(count), 32'(q.size()));
    chk("rd_valid", 32'(rd_valid), 32'(q.size() > 0));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("success", 32'(success), 32'(m_suc));
    chk("fail", 32'(fail), 32'(m_fail));
    if (q.size() > 0) begin
      chk("rd_addr", rd_addr, q[0].a);
      chk("rd_data", rd_data, q[0].d);
`ifdef MEM_TRACE_TIMESTAMP_EN
      chk("rd_time", 32'(rd_time), 32'(q[0].ts));
`else
      chk("rd_time", 32'(rd_time), 32'd0);
`endif
    end
  endtask

  task automatic cyc(input logic r, c, te, mw, input logic [31:0] a, d, input logic rr);
    reset = r; clear = c; trace_en = te; mem_write = mw; mem_addr = a; mem_wdata = d; rd_ready = rr;
    @(posedge clk);
    model_step(r, c, te, mw, a, d, rr);
    #1;
  endtask

  typedef struct {
    logic clr, te, mw; logic [31:0] addr, data; logic rr;
    int cnt; logic vld; logic [31:0] ea, ed; logic suc, fl;
  } vec_t;
  vec_t tbl[13];

  initial begin
    logic [31:0] ra, rd;
    int thr;
    tbl[0]  = '{0,1,1,32'h10,32'hA,0, 1,1,32'h10,32'hA,0,0};
    tbl[1]  = '{0,1,1,32'h14,32'hB,0, 2,1,32'h10,32'hA,0,0};
    tbl[2]  = '{0,1,1,32'h18,32'hC,0, 3,1,32'h10,32'hA,0,0};
    tbl[3]  = '{0,1,0,32'h0 ,32'h0,1, 2,1,32'h14,32'hB,0,0};
    tbl[4]  = '{0,1,0,32'h0 ,32'h0,1, 1,1,32'h18,32'hC,0,0};
    tbl[5]  = '{0,1,0,32'h0 ,32'h0,1, 0,0,32'h0 ,32'h0,0,0};
    tbl[6]  = '{0,1,1,32'd100,32'd25,0, 1,1,32'd100,32'd25,1,0};
    tbl[7]  = '{0,1,1,32'd100,32'd7 ,1, 1,1,32'd100,32'd7 ,1,1};
    tbl[8]  = '{0,1,1,32'd104,32'd25,1, 1,1,32'd104,32'd25,1,1};
    tbl[9]  = '{1,1,1,32'd100,32'd7 ,0, 0,0,32'h0,32'h0,0,0};
    tbl[10] = '{0,0,1,32'd100,32'd7 ,0, 0,0,32'h0,32'h0,0,1};
    tbl[11] = '{0,0,1,32'd100,32'd25,0, 0,0,32'h0,32'h0,1,1};
    tbl[12] = '{0,1,1,32'h20,32'h5,1, 1,1,32'h20,32'h5,1,1};

    // Reset held 2 cycles while a checked store is presented
    cyc(1,0,1,1,32'd100,32'd25,0);
    cyc(1,0,1,1,32'd100,32'd25,0);
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(rd_valid), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_suc", 32'(success), 0);
    chk("rst_fail", 32'(fail), 0);
    chk("rst_addr", rd_addr, 0);
    chk("rst_data", rd_data, 0);
    chk("rst_time", 32'(rd_time), 0);

    foreach (tbl[i]) begin
      cyc(0, tbl[i].clr, tbl[i].te, tbl[i].mw, tbl[i].addr, tbl[i].data, tbl[i].rr);
      chk($sformatf("tbl%0d_cnt", i), 32'(count), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_vld", i), 32'(rd_valid), 32'(tbl[i].vld));
      chk($sformatf("tbl%0d_suc", i), 32'(success), 32'(tbl[i].suc));
      chk($sformatf("tbl%0d_fail", i), 32'(fail), 32'(tbl[i].fl));
      if (tbl[i].vld) begin
        chk($sformatf("tbl%0d_addr", i), rd_addr, tbl[i].ea);
        chk($sformatf("tbl%0d_data", i), rd_data, tbl[i].ed);
      end
    end

`ifdef MEM_TRACE_TIMESTAMP_EN
    cyc(1,0,0,0,0,0,0);
    for (int c = 0; c < 10; c++) cyc(0,0,1,(c == 3 || c == 9),32'h40 + c,32'(c),0);
    chk("ts_first", 32'(rd_time), 3);
    cyc(0,0,0,0,0,0,1);
    chk("ts_second", 32'(rd_time), 9);
`endif

    // Fill past full, then push+pop while full
    cyc(0,1,0,0,0,0,0);
    for (int i = 0; i < 17; i++) cyc(0,0,1,1,32'h1000 + 4*i,32'(i),0);
    chk("full_count", 32'(count), 16);
    chk("full_ovf", 32'(overflow), 1);
    chk("full_head", rd_addr, 32'h1000);
    cyc(0,0,1,1,32'h2000,32'hBEEF,1);
    chk("fullpp_count", 32'(count), 16);
    chk("fullpp_head", rd_data, 1);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("drain%0d_addr", k), rd_addr, (k < 15) ? 32'h1000 + 4*(k+1) : 32'h2000);
      chk($sformatf("drain%0d_data", k), rd_data, (k < 15) ? 32'(k+1) : 32'hBEEF);
      cyc(0,0,0,0,0,0,1);
    end
    chk("drain_count", 32'(count), 0);
    chk("drain_ovf", 32'(overflow), 1);

    // Clear wins over a simultaneous checked store
    for (int i = 0; i < 5; i++) cyc(0,0,1,1,(i == 0) ? 32'd100 : 32'h300 + i,32'd7,0);
    chk("pre_clr_count", 32'(count), 5);
    chk("pre_clr_fail", 32'(fail), 1);
    cyc(0,1,1,1,32'd100,32'd25,0);
    chk("clr_count", 32'(count), 0);
    chk("clr_valid", 32'(rd_valid), 0);
    chk("clr_ovf", 32'(overflow), 0);
    chk("clr_suc", 32'(success), 0);
    chk("clr_fail", 32'(fail), 0);

    // Randomized run, varying drain pressure so full and empty both occur
    for (int n = 0; n < 4000; n++) begin
      thr = (n / 500) % 4;
      ra  = ($urandom % 4 == 0) ? 32'd100 : ($urandom % 64) * 4;
      rd  = ($urandom % 2 == 0) ? 32'd25 : $urandom;
      cyc(($urandom % 700) == 0, ($urandom % 150) == 0, ($urandom % 4) != 0,
          ($urandom % 3) != 0, ra, rd, 32'($urandom % 8) < 32'(thr * 2 + 1));
      model_check();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
